// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types plus the UART register-index helpers used by the
// AXI4-Lite front end of the 16550 register file.
package axi4_lite_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    typedef logic [AXI_ADDR_WIDTH-1:0] axi_lite_addr_t;
    typedef logic [AXI_DATA_WIDTH-1:0] axi_lite_data_t;
    typedef logic [AXI_STRB_WIDTH-1:0] axi_lite_strb_t;
    typedef logic [2:0]                axi_lite_prot_t;
    typedef logic [1:0]                axi_lite_resp_t;

    // Legacy response enum; int-sized, so ports use the 2-bit constants below.
    typedef enum {
        AXI_RESP_OKAY   = 0,
        AXI_RESP_EXOKAY = 1,
        AXI_RESP_SLVERR = 2,
        AXI_RESP_DECERR = 3
    } axi_lite_resp_enum;

    localparam axi_lite_resp_t RESP_OKAY   = 2'b00;
    localparam axi_lite_resp_t RESP_DECERR = 2'b11;

    // UART registers are byte wide and sit on a 4-byte stride.
    localparam int UART_REG_IDX_WIDTH  = 3;
    localparam int UART_REG_STRIDE_LSB = 2;

    typedef logic [UART_REG_IDX_WIDTH-1:0] uart_reg_idx_t;

    // Register index carried by an AXI byte address.
    function automatic uart_reg_idx_t uart_reg_index(input axi_lite_addr_t addr);
        return addr[UART_REG_STRIDE_LSB +: UART_REG_IDX_WIDTH];
    endfunction

endpackage

// File: rtl/uart_axi_lite_slave.sv
// AXI4-Lite slave front end for the 16550 UART register file. Independent
// write and read FSMs share a single-strobe register bus; reads win ties.
module uart_axi_lite_slave
    import axi4_lite_pkg::*;
#(
    parameter axi_lite_addr_t BASE_ADDR   = 32'h0000_0000,
    parameter int             WINDOW_BITS = 12
) (
    input  logic           clk,
    input  logic           rst,
    // write address channel
    input  axi_lite_addr_t s_awaddr,
    input  axi_lite_prot_t s_awprot,
    input  logic           s_awvalid,
    output logic           s_awready,
    // write data channel
    input  axi_lite_data_t s_wdata,
    input  axi_lite_strb_t s_wstrb,
    input  logic           s_wvalid,
    output logic           s_wready,
    // write response channel
    output axi_lite_resp_t s_bresp,
    output logic           s_bvalid,
    input  logic           s_bready,
    // read address channel
    input  axi_lite_addr_t s_araddr,
    input  axi_lite_prot_t s_arprot,
    input  logic           s_arvalid,
    output logic           s_arready,
    // read data channel
    output axi_lite_data_t s_rdata,
    output axi_lite_resp_t s_rresp,
    output logic           s_rvalid,
    input  logic           s_rready,
    // register bus
    output uart_reg_idx_t  reg_addr,
    output logic           reg_wr,
    output logic [7:0]     reg_wdata,
    output logic           reg_rd,
    input  logic [7:0]     reg_rdata
);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_PEND = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_PEND = 2'd1;
    localparam logic [1:0] R_CAP  = 2'd2;
    localparam logic [1:0] R_RESP = 2'd3;

    // Byte offsets inside the window; only the low 32 bytes hold registers.
    localparam axi_lite_addr_t WINDOW_MASK =
        (axi_lite_addr_t'(1) << WINDOW_BITS) - axi_lite_addr_t'(1);
    localparam axi_lite_addr_t HIGH_MASK = ~WINDOW_MASK;
    localparam axi_lite_addr_t MID_MASK  = WINDOW_MASK & ~axi_lite_addr_t'(32'h1F);

    // Hit when the window base matches and the offset lands in the register block.
    function automatic logic addr_hit(input axi_lite_addr_t addr);
        return (((addr ^ BASE_ADDR) & HIGH_MASK) == '0) && ((addr & MID_MASK) == '0);
    endfunction

    logic [1:0]    w_state;
    logic          aw_held;
    logic          w_held;
    uart_reg_idx_t aw_idx;
    logic          aw_hit;
    logic [7:0]    wdata_q;
    logic          wstrb0_q;

    logic [1:0]    r_state;
    uart_reg_idx_t ar_idx;
    logic          ar_hit;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic wr_need;
    logic rd_need;
    logic wr_grant;
    logic rd_grant;

    // Protection bits, upper data lanes and upper strobes carry nothing for byte registers.
    logic unused_inputs;
    assign unused_inputs = ^{s_awprot, s_arprot, s_wdata[AXI_DATA_WIDTH-1:8],
                             s_wstrb[AXI_STRB_WIDTH-1:1]};

    // Handshake outputs are forced low while reset is held so nothing is accepted.
    assign s_awready = !rst && (w_state == W_IDLE) && !aw_held;
    assign s_wready  = !rst && (w_state == W_IDLE) && !w_held;
    assign s_bvalid  = !rst && (w_state == W_RESP);
    assign s_arready = !rst && (r_state == R_IDLE);
    assign s_rvalid  = !rst && (r_state == R_RESP);

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid  && s_wready;
    assign ar_hs = s_arvalid && s_arready;

    // Only decoded hits touch the register bus; a write also needs byte lane 0.
    assign rd_need  = (r_state == R_PEND) && ar_hit;
    assign wr_need  = (w_state == W_PEND) && aw_hit && wstrb0_q;
    assign rd_grant = rd_need && !rst;
    assign wr_grant = wr_need && !rd_need && !rst;

    // Drive the register bus from whichever channel holds the grant.
    always_comb begin
        reg_rd    = rd_grant;
        reg_wr    = wr_grant;
        reg_addr  = '0;
        reg_wdata = '0;
        if (rd_grant) begin
            reg_addr = ar_idx;
        end else if (wr_grant) begin
            reg_addr  = aw_idx;
            reg_wdata = wdata_q;
        end
    end

    // Latch decoded write address and write byte at their handshakes.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            aw_idx <= uart_reg_index(s_awaddr);
            aw_hit <= addr_hit(s_awaddr);
        end
        if (w_hs) begin
            wdata_q  <= s_wdata[7:0];
            wstrb0_q <= s_wstrb[0];
        end
    end

    // Write FSM: collect AW and W in any order, issue the strobe, hold B until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            s_bresp <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) aw_held <= 1'b1;
                    if (w_hs)  w_held  <= 1'b1;
                    if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                        w_state <= W_PEND;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                    end
                end
                W_PEND: begin
                    // Wait only while a strobe is owed and the read holds the bus.
                    if (!wr_need || wr_grant) begin
                        w_state <= W_RESP;
                        s_bresp <= aw_hit ? RESP_OKAY : RESP_DECERR;
                    end
                end
                W_RESP: begin
                    if (s_bready) w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Latch decoded read address at the AR handshake.
    always_ff @(posedge clk) begin
        if (ar_hs) begin
            ar_idx <= uart_reg_index(s_araddr);
            ar_hit <= addr_hit(s_araddr);
        end
    end

    // Read FSM: strobe, capture the byte a cycle later, hold R until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            s_rdata <= '0;
            s_rresp <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) r_state <= R_PEND;
                end
                R_PEND: begin
                    // A hit always owns the bus here because reads take priority.
                    if (ar_hit) begin
                        r_state <= R_CAP;
                    end else begin
                        s_rdata <= '0;
                        s_rresp <= RESP_DECERR;
                        r_state <= R_RESP;
                    end
                end
                R_CAP: begin
                    s_rdata <= {{(AXI_DATA_WIDTH-8){1'b0}}, reg_rdata};
                    s_rresp <= RESP_OKAY;
                    r_state <= R_RESP;
                end
                R_RESP: begin
                    if (s_rready) r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_axi_lite_slave.sv
// Bench for uart_axi_lite_slave: directed latency/ordering/error/collision/
// backpressure/reset cases, then random transactions against a transaction model.
module tb_uart_axi_lite_slave;
    import axi4_lite_pkg::*;

    localparam axi_lite_addr_t BASE = 32'h4000_0000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    axi_lite_addr_t s_awaddr = '0;
    axi_lite_prot_t s_awprot = '0;
    logic           s_awvalid = 1'b0;
    logic           s_awready;
    axi_lite_data_t s_wdata = '0;
    axi_lite_strb_t s_wstrb = '0;
    logic           s_wvalid = 1'b0;
    logic           s_wready;
    axi_lite_resp_t s_bresp;
    logic           s_bvalid;
    logic           s_bready = 1'b0;
    axi_lite_addr_t s_araddr = '0;
    axi_lite_prot_t s_arprot = '0;
    logic           s_arvalid = 1'b0;
    logic           s_arready;
    axi_lite_data_t s_rdata;
    axi_lite_resp_t s_rresp;
    logic           s_rvalid;
    logic           s_rready = 1'b0;
    uart_reg_idx_t  reg_addr;
    logic           reg_wr;
    logic [7:0]     reg_wdata;
    logic           reg_rd;
    logic [7:0]     reg_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_axi_lite_slave #(.BASE_ADDR(BASE), .WINDOW_BITS(12)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
        .reg_rd(reg_rd), .reg_rdata(reg_rdata)
    );

    // Register file stand-in: cleared on reset, read data appears the cycle after reg_rd,
    // otherwise the read bus carries junk.
    logic [7:0] rf [8];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else if (reg_wr) begin
            rf[reg_addr] <= reg_wdata;
        end
        reg_rdata <= reg_rd ? rf[reg_addr] : 8'($urandom);
    end

    // Strobe monitor.
    typedef struct { time t; logic [2:0] a; logic [7:0] d; } ev_t;
    ev_t wr_log[$];
    ev_t rd_log[$];
    int  both_high = 0;
    always @(posedge clk) begin
        if (reg_wr) wr_log.push_back('{$time, reg_addr, reg_wdata});
        if (reg_rd) rd_log.push_back('{$time, reg_addr, 8'h00});
        if (reg_wr && reg_rd) both_high++;
    end

    // Transaction-level model of the register contents.
    logic [7:0] exp_regs [8];

    function automatic bit model_hit(input logic [31:0] a);
        return ((a >> 12) == (BASE >> 12)) && ((a & 32'hFFF) < 32'd32);
    endfunction

    function automatic logic [2:0] model_idx(input logic [31:0] a);
        return 3'((a & 32'h1F) / 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input axi_lite_addr_t addr, input axi_lite_data_t data,
                            input axi_lite_strb_t strb, input int d_aw, input int d_w,
                            input int bdelay);
        bit aw_done = 0;
        bit w_done  = 0;
        bit hs_aw, hs_w, hit;
        int c = 0;
        hit = model_hit(addr);
        wr_log.delete();
        s_awaddr = addr;
        s_wdata  = data;
        s_wstrb  = strb;
        s_awprot = 3'($urandom);
        while (!(aw_done && w_done) && c < 40) begin
            s_awvalid = !aw_done && (c >= d_aw);
            s_wvalid  = !w_done && (c >= d_w);
            #1;
            hs_aw = s_awvalid && s_awready;
            hs_w  = s_wvalid && s_wready;
            tick();
            aw_done = aw_done | hs_aw;
            w_done  = w_done | hs_w;
            c++;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        check("wr_accepted", 32'(aw_done && w_done), 32'd1);
        c = 0;
        while (!s_bvalid && c < 20) begin
            tick();
            c++;
        end
        check("wr_bvalid", 32'(s_bvalid), 32'd1);
        repeat (bdelay) tick();
        check("wr_bresp", 32'(s_bresp), hit ? 32'd0 : 32'd3);
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        check("wr_bvalid_clear", 32'(s_bvalid), 32'd0);
        check("wr_strobe_count", 32'(wr_log.size()), (hit && strb[0]) ? 32'd1 : 32'd0);
        if (wr_log.size() == 1) begin
            check("wr_strobe_idx", 32'(wr_log[0].a), 32'(model_idx(addr)));
            check("wr_strobe_data", 32'(wr_log[0].d), 32'(data[7:0]));
        end
        if (hit && strb[0]) exp_regs[model_idx(addr)] = data[7:0];
    endtask

    task automatic do_read(input axi_lite_addr_t addr, input int d_ar, input int rdelay);
        bit done = 0;
        bit hs, hit;
        int c = 0;
        logic [31:0] exp_data;
        hit = model_hit(addr);
        exp_data = hit ? {24'h0, exp_regs[model_idx(addr)]} : 32'h0;
        rd_log.delete();
        s_araddr = addr;
        s_arprot = 3'($urandom);
        while (!done && c < 40) begin
            s_arvalid = (c >= d_ar);
            #1;
            hs = s_arvalid && s_arready;
            tick();
            done = hs;
            c++;
        end
        s_arvalid = 1'b0;
        check("rd_accepted", 32'(done), 32'd1);
        c = 0;
        while (!s_rvalid && c < 20) begin
            tick();
            c++;
        end
        check("rd_rvalid", 32'(s_rvalid), 32'd1);
        repeat (rdelay) tick();
        check("rd_rdata", s_rdata, exp_data);
        check("rd_rresp", 32'(s_rresp), hit ? 32'd0 : 32'd3);
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        check("rd_rvalid_clear", 32'(s_rvalid), 32'd0);
        check("rd_strobe_count", 32'(rd_log.size()), hit ? 32'd1 : 32'd0);
        if (rd_log.size() == 1) check("rd_strobe_idx", 32'(rd_log[0].a), 32'(model_idx(addr)));
    endtask

    initial begin
        axi_lite_addr_t addr;
        axi_lite_data_t held_rdata;
        logic [2:0] idx;
        int kind;

        for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;

        // ---- reset values ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(s_awready), 32'd0);
        check("rst_wready", 32'(s_wready), 32'd0);
        check("rst_arready", 32'(s_arready), 32'd0);
        check("rst_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_strobes", {30'd0, reg_wr, reg_rd}, 32'd0);
        check("rst_bresp", 32'(s_bresp), 32'd0);
        check("rst_rresp", 32'(s_rresp), 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        check("rst_reg_bus", {21'd0, reg_addr, reg_wdata}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_readies", {29'd0, s_awready, s_wready, s_arready}, 32'd7);
        tick();

        // ---- write 0x83 to index 3 with exact latency ----
        wr_log.delete();
        rd_log.delete();
        s_awaddr = BASE + 32'h0C; s_wdata = 32'h0000_0083; s_wstrb = 4'h1;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        #1;
        check("A_aw_w_ready", {30'd0, s_awready, s_wready}, 32'd3);
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        check("A_reg_wr_k1", 32'(reg_wr), 32'd1);
        check("A_reg_addr_k1", 32'(reg_addr), 32'd3);
        check("A_reg_wdata_k1", 32'(reg_wdata), 32'h83);
        check("A_bvalid_k1", 32'(s_bvalid), 32'd0);
        tick();
        check("A_bvalid_k2", 32'(s_bvalid), 32'd1);
        check("A_bresp_k2", 32'(s_bresp), 32'd0);
        check("A_reg_wr_k2", 32'(reg_wr), 32'd0);
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        exp_regs[3] = 8'h83;

        s_araddr = BASE + 32'h0C; s_arvalid = 1'b1;
        #1;
        check("A_arready", 32'(s_arready), 32'd1);
        tick();
        s_arvalid = 1'b0;
        check("A_reg_rd_k1", 32'(reg_rd), 32'd1);
        check("A_reg_rd_addr_k1", 32'(reg_addr), 32'd3);
        tick();
        check("A_reg_rd_k2", 32'(reg_rd), 32'd0);
        check("A_rvalid_k2", 32'(s_rvalid), 32'd0);
        tick();
        check("A_rvalid_k3", 32'(s_rvalid), 32'd1);
        check("A_rdata_k3", s_rdata, 32'h0000_0083);
        check("A_rresp_k3", 32'(s_rresp), 32'd0);
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        check("A_wr_pulses", 32'(wr_log.size()), 32'd1);
        check("A_rd_pulses", 32'(rd_log.size()), 32'd1);

        // ---- W at cycle 0, AW at cycle 3 ----
        wr_log.delete();
        s_wdata = 32'h0000_0055; s_wstrb = 4'h1; s_awaddr = BASE;
        s_wvalid = 1'b1;
        #1;
        check("B_wready_c0", 32'(s_wready), 32'd1);
        tick();
        s_wvalid = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            check("B_wready_held", 32'(s_wready), 32'd0);
            check("B_awready_open", 32'(s_awready), 32'd1);
            tick();
        end
        s_awvalid = 1'b1;
        #1;
        check("B_awready_c3", 32'(s_awready), 32'd1);
        tick();
        s_awvalid = 1'b0;
        check("B_reg_wr_c4", 32'(reg_wr), 32'd1);
        check("B_reg_addr_c4", 32'(reg_addr), 32'd0);
        check("B_reg_wdata_c4", 32'(reg_wdata), 32'h55);
        check("B_bvalid_c4", 32'(s_bvalid), 32'd0);
        tick();
        check("B_bvalid_c5", 32'(s_bvalid), 32'd1);
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        exp_regs[0] = 8'h55;

        // ---- decode errors and lane-0 strobe ----
        do_write(BASE + 32'h20, 32'h0000_00AA, 4'h1, 0, 0, 0);
        do_read(BASE + 32'h1000, 0, 0);
        do_write(BASE + 32'h04, 32'h0000_0077, 4'hE, 0, 0, 0);
        do_read(BASE + 32'h04, 0, 0);

        // ---- collision: read wins, write next cycle ----
        wr_log.delete();
        rd_log.delete();
        s_awaddr = BASE + 32'h14; s_wdata = 32'h0000_00A5; s_wstrb = 4'h1;
        s_araddr = BASE + 32'h0C;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        check("D_n_strobes", {30'd0, reg_rd, reg_wr}, 32'd2);
        check("D_n_addr", 32'(reg_addr), 32'd3);
        tick();
        check("D_n1_strobes", {30'd0, reg_rd, reg_wr}, 32'd1);
        check("D_n1_addr", 32'(reg_addr), 32'd5);
        check("D_n1_wdata", 32'(reg_wdata), 32'hA5);
        tick();
        check("D_bvalid", 32'(s_bvalid), 32'd1);
        check("D_rvalid", 32'(s_rvalid), 32'd1);
        check("D_rdata", s_rdata, 32'h0000_0083);
        s_bready = 1'b1; s_rready = 1'b1;
        tick();
        s_bready = 1'b0; s_rready = 1'b0;
        exp_regs[5] = 8'hA5;

        // ---- backpressure for 10 cycles on both response channels ----
        s_awaddr = BASE + 32'h18; s_wdata = 32'h0000_003C; s_wstrb = 4'h1;
        s_araddr = BASE + 32'h14;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        repeat (2) tick();
        held_rdata = s_rdata;
        check("E_rdata_initial", held_rdata, 32'h0000_00A5);
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        s_awaddr = BASE + 32'h1C; s_araddr = BASE + 32'h1C;
        for (int c = 0; c < 10; c++) begin
            check("E_bvalid_held", 32'(s_bvalid), 32'd1);
            check("E_bresp_held", 32'(s_bresp), 32'd0);
            check("E_rvalid_held", 32'(s_rvalid), 32'd1);
            check("E_rdata_held", s_rdata, 32'h0000_00A5);
            check("E_rresp_held", 32'(s_rresp), 32'd0);
            check("E_readies_low", {29'd0, s_awready, s_wready, s_arready}, 32'd0);
            tick();
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        s_bready = 1'b1; s_rready = 1'b1;
        tick();
        s_bready = 1'b0; s_rready = 1'b0;
        exp_regs[6] = 8'h3C;
        do_read(BASE + 32'h18, 0, 0);

        // ---- reset while the read is pending ----
        rd_log.delete();
        s_araddr = BASE + 32'h0C; s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        rst = 1'b1;
        #1;
        check("F_no_reg_rd", 32'(reg_rd), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("F_arready_after", 32'(s_arready), 32'd1);
        check("F_rvalid_after", 32'(s_rvalid), 32'd0);
        for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
        repeat (4) begin
            tick();
            check("F_rvalid_quiet", 32'(s_rvalid), 32'd0);
        end
        check("F_rd_pulses", 32'(rd_log.size()), 32'd0);

        // ---- random transactions ----
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 5);
            idx  = 3'($urandom_range(0, 7));
            if (kind <= 3)
                addr = BASE + 32'(idx) * 4 + 32'($urandom_range(0, 3));
            else if (kind == 4)
                addr = BASE ^ (32'h1 << $urandom_range(12, 31));
            else
                addr = BASE + (32'h20 << $urandom_range(0, 6)) + 32'(idx) * 4;
            if ($urandom_range(0, 1) == 1)
                do_write(addr, $urandom, 4'($urandom), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(addr, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        check("never_both_strobes", 32'(both_high), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_axi_lite_slave.md
Name: uart_axi_lite_slave

Overview:
- AXI4-Lite slave front end for the 16550 UART register file; sits between the system interconnect and the UART register block.
- Accepts independent write and read channels, decodes 8 byte-wide UART registers on a 4-byte stride and issues single-cycle strobes on a simple register bus.
- Returns OKAY or DECERR responses using the axi4_lite_pkg types.

Parameters:
- BASE_ADDR, 32'h0000_0000: base of the decode window; must be aligned to 2^WINDOW_BITS.
- WINDOW_BITS, 12: window size is 2^WINDOW_BITS bytes.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- s_awaddr in 32 / s_awprot in 3 / s_awvalid in 1 / s_awready out 1: write address channel
- s_wdata in 32 / s_wstrb in 4 / s_wvalid in 1 / s_wready out 1: write data channel
- s_bresp out 2 / s_bvalid out 1 / s_bready in 1: write response channel
- s_araddr in 32 / s_arprot in 3 / s_arvalid in 1 / s_arready out 1: read address channel
- s_rdata out 32 / s_rresp out 2 / s_rvalid out 1 / s_rready in 1: read data channel
- reg_addr  out 3  UART register index
- reg_wr  out 1  one-cycle write strobe
- reg_wdata  out 8  write byte
- reg_rd  out 1  one-cycle read strobe; has side effects, e.g. RBR pop
- reg_rdata  in 8  register file read data, valid the cycle after reg_rd

Behaviour:
- Reset values: all ready, valid and strobe outputs are 0; s_bresp, s_rresp, s_rdata, reg_addr and reg_wdata are 0. Both FSMs return to IDLE; any latched address or data is discarded.
- Decode: hit requires addr[31:WINDOW_BITS] == BASE_ADDR[31:WINDOW_BITS] and addr[WINDOW_BITS-1:5] == 0. Index = addr[4:2]. addr[1:0] is ignored. AxPROT is ignored. A miss gives DECERR (2'b11). A hit gives OKAY (2'b00).
- Write FSM: W_IDLE, W_PEND, W_RESP.
  - W_IDLE: s_awready = 1 until AW is captured; s_wready = 1 until W is captured. AW and W are accepted in either order or in the same cycle.
  - When both are held, go to W_PEND.
  - W_PEND, hit with wstrb[0] = 1: assert reg_wr for one cycle when granted, with reg_addr = index and reg_wdata = wdata[7:0]; then go to W_RESP.
  - W_PEND, hit with wstrb[0] = 0: no reg_wr; go to W_RESP next cycle with OKAY.
  - W_PEND, miss: no reg_wr; go to W_RESP next cycle with DECERR.
  - W_RESP: s_bvalid = 1 and s_bresp is held stable until s_bready; then return to W_IDLE. No new AW or W is accepted until then.
- Read FSM: R_IDLE, R_PEND, R_CAP, R_RESP.
  - R_IDLE: s_arready = 1. On handshake, latch the address and go to R_PEND.
  - R_PEND, hit: assert reg_rd for one cycle when granted, then go to R_CAP.
  - R_PEND, miss: no reg_rd; s_rdata = 0, DECERR; go to R_RESP.
  - R_CAP: latch s_rdata = {24'h0, reg_rdata} with OKAY, then go to R_RESP.
  - R_RESP: s_rvalid = 1 and s_rdata/s_rresp are held stable until s_rready; then return to R_IDLE.
- Register bus arbitration:
  - At most one of reg_wr and reg_rd is asserted in any cycle.
  - If W_PEND and R_PEND both need the bus in the same cycle, the read wins and the write issues the next cycle.
  - Each channel has at most one outstanding transaction, so there is no starvation.
- Minimum latency:
  - Write: AW and W handshakes at cycle k → reg_wr at k+1 → s_bvalid at k+2.
  - Read: AR handshake at k → reg_rd at k+1 → capture at k+2 → s_rvalid at k+3.
- Valid outputs never drop without the matching ready. A stalled s_bready or s_rready blocks only its own channel.
- rst asserted mid-transaction aborts it immediately: no strobe is issued and no response is produced.

Decomposition:
- Add to axi4_lite_pkg:
  - UART_REG_IDX_WIDTH = 3
  - UART_REG_STRIDE_LSB = 2
  - typedef uart_reg_idx_t
  - 2-bit response constants RESP_OKAY = 2'b00 and RESP_DECERR = 2'b11, used instead of the int-sized axi_lite_resp_enum
  - Fix axi_lite_data_t to use AXI_DATA_WIDTH.
- Use package typedefs for all AXI ports.
- No sub-module. Both FSMs and the arbiter live in one file, about 250 lines.

Test Plan:
- Write first, then read: AW addr 0x0C with W data 0x0000_0083, wstrb 4'h1; then AR addr 0x0C with reg_rdata = 0x83.
  - reg_wr pulses once at index 3 with data 0x83; bresp OKAY at k+2.
  - reg_rd pulses once at index 3; rdata 0x0000_0083, rresp OKAY at k+3.
- W before AW: W 0x55 at cycle 0, AW 0x00 at cycle 3. reg_wr at cycle 4, index 0, data 0x55; s_bvalid at cycle 5.
- Decode errors:
  - Write to 0x20 → DECERR, no reg_wr.
  - Read from BASE_ADDR + 0x1000 → rdata 0, DECERR, no reg_rd.
  - Write with wstrb 4'hE to 0x04 → OKAY, no reg_wr.
- Collision: W_PEND and R_PEND coincide. reg_rd fires at cycle n, reg_wr at n+1, never both high in one cycle.
- Backpressure: s_bready and s_rready held low for 10 cycles. s_bvalid and s_rvalid held with stable data; s_awready and s_arready stay 0 throughout.
- Reset mid-read: rst asserted in R_PEND. No reg_rd, s_rvalid stays 0, s_arready = 1 in the first cycle after rst deasserts.
